phase_vec_avg: RTL and testbench

- Consumes the per-channel phase stream produced by the eigenvector arctan2 stage.
- The input is one phase word per frequency channel, VECTOR_LEN channels per vector.
- Averages each channel's phase over 2^ACC_LOG2 consecutive vectors using a BRAM read-modify-write accumulator.
- Emits one averaged vector, tagged with channel index, to the DoA estimation stage.

---
 rtl/phase_vec_avg.sv | 94 +++++++++
 tb/tb_phase_vec_avg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_vec_avg.sv
// phase_vec_avg: per-channel phase mean over 2^ACC_LOG2 vectors via BRAM read-modify-write
module phase_vec_avg #(
  parameter int DIN_WIDTH  = 16,
  parameter int VECTOR_LEN = 512,
  parameter int ACC_LOG2   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          clear,
  input  logic signed [DIN_WIDTH-1:0]   phase,
  input  logic                          phase_valid,
  output logic signed [DIN_WIDTH-1:0]   dout,
  output logic [$clog2(VECTOR_LEN)-1:0] dout_index,
  output logic                          dout_valid,
  output logic                          dout_last
);
  localparam int CW = $clog2(VECTOR_LEN);
  localparam int AW = DIN_WIDTH + ACC_LOG2;
  logic [CW-1:0] ch_q, ch_d, s1_ch_q, s1_ch_d, wr_ch_q, wr_ch_d, idx_q, idx_d;
  logic [ACC_LOG2-1:0] fr_q, fr_d;
  logic signed [DIN_WIDTH-1:0] s1_ph_q, s1_ph_d, dout_q, dout_d;
  logic s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_final_q, s1_final_d;
  logic wr_v_q, wr_v_d, vld_q, vld_d, last_q, last_d, acc;
  logic signed [AW-1:0] wr_sum_q, wr_sum_d, sum, rd_q;
  logic signed [AW-1:0] mem [VECTOR_LEN];

  always_comb begin
    acc        = phase_valid & ~clear;
    ch_d       = clear ? '0 : acc ? ch_q + 1'b1 : ch_q;
    fr_d       = clear ? '0 : (acc && &ch_q) ? fr_q + 1'b1 : fr_q;
    s1_v_d     = acc;
    s1_ph_d    = phase;
    s1_ch_d    = ch_q;
    s1_first_d = fr_q == '0;
    s1_final_d = &fr_q;
    // first frame of a run overwrites, so the BRAM never needs clearing
    sum        = {{ACC_LOG2{s1_ph_q[DIN_WIDTH-1]}}, s1_ph_q} + (s1_first_q ? '0 : rd_q);
    wr_v_d     = s1_v_q;
    wr_ch_d    = s1_ch_q;
    wr_sum_d   = sum;
    vld_d      = s1_v_q & s1_final_q;
    dout_d     = vld_d ? sum[AW-1:ACC_LOG2] : dout_q;
    idx_d      = vld_d ? s1_ch_q : idx_q;
    last_d     = vld_d ? &s1_ch_q : last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q       <= '0;
      fr_q       <= '0;
      s1_v_q     <= 1'b0;
      s1_ph_q    <= '0;
      s1_ch_q    <= '0;
      s1_first_q <= 1'b0;
      s1_final_q <= 1'b0;
      wr_v_q     <= 1'b0;
      wr_ch_q    <= '0;
      wr_sum_q   <= '0;
      vld_q      <= 1'b0;
      dout_q     <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
    end else if (ce) begin
      ch_q       <= ch_d;
      fr_q       <= fr_d;
      s1_v_q     <= s1_v_d;
      s1_ph_q    <= s1_ph_d;
      s1_ch_q    <= s1_ch_d;
      s1_first_q <= s1_first_d;
      s1_final_q <= s1_final_d;
      wr_v_q     <= wr_v_d;
      wr_ch_q    <= wr_ch_d;
      wr_sum_q   <= wr_sum_d;
      vld_q      <= vld_d;
      dout_q     <= dout_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
    end
  end

  // same address recurs only after >= 4 accepts, so write-back lands before the next read
  always_ff @(posedge clk) begin
    if (ce) begin
      rd_q <= mem[ch_q];
      if (wr_v_q) mem[wr_ch_q] <= wr_sum_q;
    end
  end

  assign dout       = dout_q;
  assign dout_index = idx_q;
  assign dout_valid = vld_q;
  assign dout_last  = last_q;
endmodule

// File: tb/tb_phase_vec_avg.sv
// tb_phase_vec_avg: table vectors, random gaps/ce and corner sequences against a per-channel mean model
module tb_phase_vec_avg;
  localparam int VL = 8;
  localparam int NA = 4;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b1, clear = 1'b0, phase_valid = 1'b0;
  logic signed [15:0] phase = '0, dout;
  logic [2:0] dout_index;
  logic dout_valid, dout_last;
  int total = 0, bad = 0, ce_edges = 0, n_out = 0, n_acc = 0, prev = 0;
  bit ce_e = 1'b0, rst_p = 1'b0;
  int sums[VL], cnts[VL], got[VL];
  typedef struct {int d; int idx; int last; int edge_n;} exp_t;
  exp_t eq[$];
  typedef struct {int p0; int p1; int p2; int p3; int e;} vec_t;
  vec_t tbl[6];

  phase_vec_avg #(.DIN_WIDTH(16), .VECTOR_LEN(VL), .ACC_LOG2(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clear(clear), .phase(phase), .phase_valid(phase_valid),
    .dout(dout), .dout_index(dout_index), .dout_valid(dout_valid), .dout_last(dout_last)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int a, input int b);
    total++;
    if (a !== b) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, b);
    end
  endtask

  task automatic model_reset();
    n_acc = 0;
    for (int c = 0; c < VL; c++) begin
      sums[c] = 0;
      cnts[c] = 0;
    end
    eq.delete();
  endtask

  // mean of the last NA samples seen by a channel, floored toward -inf
  task automatic model_accept(input int v);
    int c, s;
    exp_t e;
    c = n_acc % VL;
    sums[c] += v;
    cnts[c]++;
    if (cnts[c] == NA) begin
      s = sums[c];
      e.d = (s - (((s % NA) + NA) % NA)) / NA;
      e.idx = c;
      e.last = (c == VL - 1) ? 1 : 0;
      e.edge_n = ce_edges + 1;
      eq.push_back(e);
      sums[c] = 0;
      cnts[c] = 0;
    end
    n_acc++;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst && ce) begin
      ce_edges++;
      if (clear) model_reset();
      else if (phase_valid) model_accept(int'(phase));
    end
    ce_e = ce;
    #1;
  endtask

  task automatic cyc(input bit c, input bit pv, input bit cl, input int v);
    ce = c;
    phase_valid = pv;
    clear = cl;
    phase = 16'(v);
    step();
  endtask

  function automatic int rnd_ph();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic send(input int v, input bit rnd);
    if (rnd)
      repeat ($urandom_range(0, 5)) begin
        if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b1, 1'b0, rnd_ph());
        else cyc(1'b1, 1'b0, 1'b0, rnd_ph());
      end
    cyc(1'b1, 1'b1, 1'b0, v);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic run_vec(input int p0, input int p1, input int p2, input int p3, input bit rnd);
    int pp[4];
    pp = '{p0, p1, p2, p3};
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < VL; c++) send(pp[f], rnd);
  endtask

  task automatic run_rand(input int nvec, input bit rnd);
    repeat (nvec * VL) send(rnd_ph(), rnd);
  endtask

  initial forever begin
    int cur;
    exp_t e;
    @(negedge clk);
    cur = int'({dout, dout_index, dout_valid, dout_last});
    if (rst && ce_e && dout_valid) begin
      if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious dout_valid idx=%0d dout=%0d want=none", dout_index, dout);
      end else begin
        e = eq.pop_front();
        chk("dout", int'(dout), e.d);
        chk("dout_index", int'(dout_index), e.idx);
        chk("dout_last", int'(dout_last), e.last);
        chk("latency_edge", ce_edges, e.edge_n);
      end
      got[dout_index] = int'(dout);
      n_out++;
    end
    if (rst && eq.size() > 0 && eq[0].edge_n < ce_edges) begin
      total++;
      bad++;
      $display("FAIL missing output idx=%0d got=none want=%0d", eq[0].idx, eq[0].d);
      void'(eq.pop_front());
    end
    if (rst && rst_p && !ce_e) chk("hold_ce0", cur, prev);
    prev = cur;
    rst_p = rst;
  end

  initial begin
    int n0;
    tbl[0] = '{1000, 1000, 1000, 1000, 1000};
    tbl[1] = '{10, 20, 30, 44, 26};
    tbl[2] = '{-1, -2, -3, -4, -3};
    tbl[3] = '{-32768, -32768, -32768, -32768, -32768};
    tbl[4] = '{32767, 32767, 32767, 32767, 32767};
    tbl[5] = '{32767, -32768, 32767, -32768, -1};
    model_reset();
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 123);
    chk("rst_dout", int'(dout), 0);
    chk("rst_index", int'(dout_index), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_last", int'(dout_last), 0);
    rst = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < VL; c++) got[c] = -99999;
      n0 = n_out;
      run_vec(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3, 1'b0);
      idle(4);
      chk($sformatf("tbl%0d_count", i), n_out - n0, VL);
      for (int c = 0; c < VL; c++) chk($sformatf("tbl%0d_ch%0d", i, c), got[c], tbl[i].e);
    end

    for (int c = 0; c < VL; c++) got[c] = -99999;
    n0 = n_out;
    run_vec(1000, 1000, 1000, 1000, 1'b1);
    idle(4);
    chk("gap_count", n_out - n0, VL);
    for (int c = 0; c < VL; c++) chk($sformatf("gap_ch%0d", c), got[c], 1000);
    n0 = n_out;
    run_rand(12, 1'b1);
    idle(4);
    chk("rand_count", n_out - n0, 3 * VL);

    run_rand(2, 1'b0);
    repeat (4) send(7777, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 7777);
    for (int c = 0; c < VL; c++) got[c] = -99999;
    n0 = n_out;
    run_vec(500, 500, 500, 500, 1'b0);
    idle(4);
    chk("clear_count", n_out - n0, VL);
    for (int c = 0; c < VL; c++) chk($sformatf("clear_ch%0d", c), got[c], 500);

    for (int f = 0; f < 3; f++)
      for (int c = 0; c < VL; c++) send(100, 1'b0);
    for (int c = 0; c < 3; c++) send(100, 1'b0);
    #2;
    chk("rst_mid_valid", int'(dout_valid), 1);
    rst = 1'b0;
    #1;
    chk("arst_dout", int'(dout), 0);
    chk("arst_index", int'(dout_index), 0);
    chk("arst_valid", int'(dout_valid), 0);
    chk("arst_last", int'(dout_last), 0);
    model_reset();
    idle(2);
    rst = 1'b1;
    idle(1);
    n0 = n_out;
    run_rand(3, 1'b0);
    chk("arst_early", n_out - n0, 0);
    run_rand(1, 1'b0);
    idle(4);
    chk("arst_count", n_out - n0, VL);

    idle(4);
    chk("drain", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
